// File: rtl/mips_div_pkg.sv
// Shared definitions for the iterative MIPS divider: FSM encoding and iteration sizing.
package mips_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

  localparam int unsigned DIV_CNT_W = 5;
  localparam int unsigned DIV_ITER  = 32;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] remShift;
  logic           geq;

  // Trial subtraction; the MSB of the shifted remainder takes part in the compare only,
  // the kept remainder is the low WIDTH bits (a zero divisor just accumulates the dividend).
  always_comb begin
    remShift = {remIn, quoIn[WIDTH-1]};
    geq      = (remShift >= {1'b0, divisor});
    quoOut   = {quoIn[WIDTH-2:0], geq};
    remOut   = geq ? (remShift[WIDTH-1:0] - divisor) : remShift[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_div.sv
// Iterative radix-2 DIV/DIVU unit for the execute stage. Holds the pipeline through
// stall_divE until HI (remainder) / LO (quotient) are ready.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes from IDLE straight to DONE.
module mips_div
  import mips_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] aE,
  input  logic [WIDTH-1:0] bE,
  input  logic             annul,
  output logic             stall_divE,
  output logic             readyE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  localparam logic [DIV_CNT_W-1:0] LastCnt = DIV_CNT_W'(WIDTH - 1);

  divState_t            stateQ, stateD;
  logic [DIV_CNT_W-1:0] cntQ, cntD;
  logic [WIDTH-1:0]     remQ, remD, quoQ, quoD, absBQ, absBD;
  logic                 negQuoQ, negQuoD, negRemQ, negRemD;
  logic [WIDTH-1:0]     hiQ, hiD, loQ, loD;
  logic [WIDTH-1:0]     remStep, quoStep;
  logic                 aNeg, bNeg;
  logic [WIDTH-1:0]     absA, absB;

  // Operand magnitudes; sign bits count only for signed DIV.
  always_comb begin
    aNeg = signedE & aE[WIDTH-1];
    bNeg = signedE & bE[WIDTH-1];
    absA = aNeg ? (~aE + WIDTH'(1)) : aE;
    absB = bNeg ? (~bE + WIDTH'(1)) : bE;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .remIn   (remQ),
    .quoIn   (quoQ),
    .divisor (absBQ),
    .remOut  (remStep),
    .quoOut  (quoStep)
  );

  // Next-state, datapath and handshake outputs.
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    remD       = remQ;
    quoD       = quoQ;
    absBD      = absBQ;
    negQuoD    = negQuoQ;
    negRemD    = negRemQ;
    hiD        = hiQ;
    loD        = loQ;
    stall_divE = 1'b0;
    readyE     = 1'b0;
    unique case (stateQ)
      DIV_IDLE: begin
        if (startE) begin
          stall_divE = 1'b1;
          remD       = '0;
          quoD       = absA;
          absBD      = absB;
          negQuoD    = aNeg ^ bNeg;
          negRemD    = aNeg;
          cntD       = '0;
          stateD     = DIV_BUSY;
`ifdef DIV_ZERO_FAST_EN
          // Preload what 32 iterations with b == 0 would leave behind.
          if (bE == '0) begin
            remD   = absA;
            quoD   = '1;
            stateD = DIV_DONE;
          end
`endif
        end
      end
      DIV_BUSY: begin
        stall_divE = 1'b1;
        remD       = remStep;
        quoD       = quoStep;
        cntD       = cntQ + DIV_CNT_W'(1);
        if (cntQ == LastCnt) stateD = DIV_DONE;
      end
      DIV_DONE: begin
        readyE = 1'b1;
        hiD    = negRemQ ? (~remQ + WIDTH'(1)) : remQ;
        loD    = negQuoQ ? (~quoQ + WIDTH'(1)) : quoQ;
        stateD = DIV_IDLE;
      end
      default: stateD = DIV_IDLE;
    endcase
    // Exception flush overrides everything and leaves the published result untouched.
    if (annul) begin
      stall_divE = 1'b0;
      readyE     = 1'b0;
      stateD     = DIV_IDLE;
      cntD       = '0;
      hiD        = hiQ;
      loD        = loQ;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= DIV_IDLE;
      cntQ    <= '0;
      remQ    <= '0;
      quoQ    <= '0;
      absBQ   <= '0;
      negQuoQ <= 1'b0;
      negRemQ <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      remQ    <= remD;
      quoQ    <= quoD;
      absBQ   <= absBD;
      negQuoQ <= negQuoD;
      negRemQ <= negRemD;
      hiQ     <= hiD;
      loQ     <= loD;
    end
  end

  assign hiE = hiQ;
  assign loE = loQ;

endmodule

// File: tb/tb_mips_div.sv
// Scoreboard bench for mips_div: stimulus pushes expected {hi, lo}; a monitor checks the
// result registers the cycle after each readyE pulse.
module tb_mips_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic [31:0] aE;
  logic [31:0] bE;
  logic        annul;
  logic        stall_divE;
  logic        readyE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] expQ[$];
  logic [63:0] curExp;
  bit          chkPending = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZeroStall = 1;
`else
  localparam int ZeroStall = 33;
`endif

  mips_div #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .aE         (aE),
    .bE         (bE),
    .annul      (annul),
    .stall_divE (stall_divE),
    .readyE     (readyE),
    .hiE        (hiE),
    .loE        (loE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: results are registered at the end of the readyE cycle.
  always @(negedge clk) begin
    if (chkPending) begin
      chkPending = 0;
      check("hiE", hiE, curExp[63:32]);
      check("loE", loE, curExp[31:0]);
    end
    if (readyE) begin
      if (expQ.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL unexpected_ready: got readyE=1 expected 0 at cycle %0d", cyc);
      end else begin
        curExp     = expQ.pop_front();
        chkPending = 1;
      end
    end
  end

  // Issue one divide at the current cycle (called just after a posedge) and wait for readyE.
  task automatic doDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo,
                       input int expStall, input bit keep, output int readyAt);
    int  n;
    int  stalls;
    bit  got;
    expQ.push_back({expHi, expLo});
    startE  = 1'b1;
    signedE = sgn;
    aE      = a;
    bE      = b;
    n       = 0;
    stalls  = 0;
    got     = 0;
    readyAt = -1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (stall_divE) stalls++;
      if (readyE) begin
        got     = 1;
        readyAt = cyc;
      end
      n++;
    end
    total = total + 1;
    if (!got) begin
      bad = bad + 1;
      $display("FAIL ready_timeout: got no readyE within %0d cycles expected a pulse", n);
    end
    check("stall_cycles", 32'(stalls), 32'(expStall));
    @(posedge clk);
    #1;
    if (!keep) startE = 1'b0;
  endtask

  initial begin
    int r0, r1;
    rst     = 1'b1;
    startE  = 1'b0;
    signedE = 1'b0;
    aE      = '0;
    bE      = '0;
    annul   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'b0, stall_divE}, 32'd0);
    check("rst_ready", {31'b0, readyE}, 32'd0);
    check("rst_hi", hiE, 32'd0);
    check("rst_lo", loE, 32'd0);
    @(posedge clk);
    #1;

    doDiv(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, r0);
    doDiv(1'b1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, r0);
    doDiv(1'b1, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD, 33, 1'b0, r0);
    doDiv(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 1'b0, r0);
    doDiv(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, ZeroStall, 1'b0, r0);
    doDiv(1'b1, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'd1, ZeroStall, 1'b0, r0);
    repeat (2) @(posedge clk);
    #1;

    // Annul at the 10th BUSY cycle.
    startE  = 1'b1;
    signedE = 1'b0;
    aE      = 32'd1000;
    bE      = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul  = 1'b1;
    startE = 1'b0;
    @(negedge clk);
    check("annul_stall", {31'b0, stall_divE}, 32'd0);
    check("annul_ready", {31'b0, readyE}, 32'd0);
    @(posedge clk);
    #1;
    annul = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_annul_stall", {31'b0, stall_divE}, 32'd0);
    end
    check("annul_hold_hi", hiE, 32'hFFFFFFFB);
    check("annul_hold_lo", loE, 32'd1);
    @(posedge clk);
    #1;
    doDiv(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33, 1'b0, r0);

    // Back-to-back with startE held high.
    doDiv(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1, r0);
    doDiv(1'b0, 32'd50, 32'd8, 32'd2, 32'd6, 33, 1'b0, r1);
    check("b2b_spacing", 32'(r1 - r0), 32'd34);

    // Reset at BUSY cycle 5.
    startE  = 1'b1;
    signedE = 1'b1;
    aE      = 32'd77;
    bE      = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    rst    = 1'b1;
    startE = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", {31'b0, stall_divE}, 32'd0);
    check("midrst_ready", {31'b0, readyE}, 32'd0);
    check("midrst_hi", hiE, 32'd0);
    check("midrst_lo", loE, 32'd0);
    @(posedge clk);
    #1;
    doDiv(1'b1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, r0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
